// File: rtl/instr_sequencer_if.sv
// Handshake/bus bundle between the instruction sequencer and its host/core.
// master: host side (drives program load, control and core feedback).
// slave:  sequencer side.
interface instr_sequencer_if #(
  parameter int DEPTH = 16,
  parameter int IW    = 6,
  parameter int OW    = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [IW-1:0] wr_data;
  logic          clear;
  logic          start;
  logic          loop_en;
  logic          stop;
  logic [OW-1:0] io_in;
  logic [IW-1:0] instr;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;
  logic          overflow;
  logic [OW-1:0] signature;
  logic [OW-1:0] last_out;

  modport master (
    output wr_en, wr_data, clear, start, loop_en, stop, io_in,
    input  instr, busy, done, count, overflow, signature, last_out
  );

  modport slave (
    input  wr_en, wr_data, clear, start, loop_en, stop, io_in,
    output instr, busy, done, count, overflow, signature, last_out
  );
endinterface

// File: rtl/instr_sequencer.sv
// Program buffer + replay engine for the 6-bit-instruction core.
// Loads words in IDLE, replays them one per cycle, and folds the core's
// delayed responses into a rotate-XOR signature.
//
// state   | meaning
// --------+--------------------------------------------------------
// S_IDLE  | accept clear / start / program writes
// S_RUN   | issue mem[rd_ptr] each cycle, wrap when looping
// S_DRAIN | one NOP cycle so the last response can be sampled
// S_DONE  | one-cycle done pulse, then back to S_IDLE
module instr_sequencer #(
  parameter int DEPTH = 16,
  parameter int IW    = 6,
  parameter int OW    = 8
) (
  input  logic clk,
  input  logic rst,
  instr_sequencer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr, w_rd_ptr_nxt;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_stop_req;
  logic          r_prev_run;
  logic [IW-1:0] r_instr;
  logic [OW-1:0] r_signature;
  logic [OW-1:0] r_last_out;
  logic          w_start_ok, w_write_ok, w_at_last;
  logic          w_busy, w_done;

  // A start with an empty buffer is treated as absent, so a coincident write still lands.
  assign w_start_ok = (r_state == S_IDLE) && !bus.clear && bus.start && (r_count != '0);
  assign w_write_ok = (r_state == S_IDLE) && !bus.clear && !w_start_ok && bus.wr_en;
  assign w_at_last  = ({1'b0, r_rd_ptr} == (r_count - ONE));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state and read pointer; a latched stop prevents the wrap but never cuts a pass short
  always_comb begin
    w_state_nxt  = r_state;
    w_rd_ptr_nxt = r_rd_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt  = S_RUN;
          w_rd_ptr_nxt = '0;
        end
      end
      S_RUN: begin
        if (w_at_last) begin
          if (bus.loop_en && !bus.stop && !r_stop_req) w_rd_ptr_nxt = '0;
          else                                         w_state_nxt  = S_DRAIN;
        end else begin
          w_rd_ptr_nxt = r_rd_ptr + 1'b1;
        end
      end
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state register
  always_comb begin
    w_busy = (r_state == S_RUN) || (r_state == S_DRAIN);
    w_done = (r_state == S_DONE);
  end

  // Datapath: pointer, instruction register, count/overflow, response capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_stop_req  <= 1'b0;
      r_prev_run  <= 1'b0;
      r_instr     <= '0;
      r_signature <= '0;
      r_last_out  <= '0;
    end else begin
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_instr    <= (w_state_nxt == S_RUN) ? r_mem[w_rd_ptr_nxt] : '0;
      r_prev_run <= (r_state == S_RUN);
      r_stop_req <= (r_state == S_RUN) && (r_stop_req || bus.stop);
      if ((r_state == S_IDLE) && bus.clear) begin
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else if (w_write_ok) begin
        if (r_count != FULL) r_count    <= r_count + ONE;
        else                 r_overflow <= 1'b1;
      end
      // Core answers one cycle late: sample whenever the previous cycle issued an instruction
      if (w_start_ok) begin
        r_signature <= '0;
      end else if (r_prev_run) begin
        r_signature <= {r_signature[OW-2:0], r_signature[OW-1]} ^ bus.io_in;
        r_last_out  <= bus.io_in;
      end
    end
  end

  // Program buffer; contents survive reset and clear, count gates visibility
  always_ff @(posedge clk) begin
    if (w_write_ok && (r_count != FULL)) r_mem[r_count[PW-1:0]] <= bus.wr_data;
  end

  assign bus.instr     = r_instr;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;
  assign bus.signature = r_signature;
  assign bus.last_out  = r_last_out;
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Stimulus-side companion to the 6-bit-instruction core in `top`.
- Holds a small program buffer loaded one word at a time and replays it into the core's `instr` port, one instruction per cycle.
- Samples the core's 8-bit `io_out` for each issued instruction and folds the samples into a signature.
- Used on-chip for self-test, and on the bench as the driver/monitor pair for `top`.

Parameters:
DEPTH, 16, program buffer entries (power of two, 2..64)
IW, 6, instruction width
OW, 8, core output width

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous active-low reset
wr_en  input  1  load strobe, honoured only in IDLE
wr_data  input  IW  program word to append
clear  input  1  empty the program buffer, honoured only in IDLE
start  input  1  begin replay, honoured only in IDLE
loop_en  input  1  replay continuously until stop
stop  input  1  end a looping replay
io_in  input  OW  core io_out, fed back
instr  output  IW  instruction to core
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse at end of replay
count  output  log2(DEPTH)+1  words loaded
overflow  output  1  sticky: write attempted while full
signature  output  OW  running response signature
last_out  output  OW  most recent sampled io_in

Behaviour:
- Reset (rst=0, async) clears all state: state=IDLE, instr=0, busy=0, done=0, count=0, overflow=0, signature=0, last_out=0, rd_ptr=0. Buffer contents are not cleared; count=0 makes them unreachable. Reset mid-RUN aborts immediately with no done pulse.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, priority clear > start > wr_en:
  - clear: count=0, overflow=0.
  - start with count>0: rd_ptr=0, signature=0, go to RUN. start with count==0 is ignored.
  - wr_en with count<DEPTH: mem[count]=wr_data, count+1. wr_en with count==DEPTH: dropped, overflow=1.
- RUN:
  - instr = mem[rd_ptr], registered, so it changes on the clock edge.
  - rd_ptr increments each cycle.
  - At rd_ptr==count-1:
    - loop_en=1 and stop=0: rd_ptr wraps to 0.
    - otherwise: go to DRAIN.
  - stop sampled mid-program with loop_en=1: the current pass finishes, then DRAIN. stop never truncates a pass.
  - wr_en, clear and start are ignored outside IDLE.
- DRAIN: one cycle, instr=0 (NOP), then DONE.
- DONE: done=1 for exactly one cycle, instr=0, then IDLE.
- instr=0 in every state except RUN.
- Response capture:
  - The core has 1-cycle latency, so io_in is sampled on every cycle whose previous cycle was RUN. This covers each RUN cycle after the first, plus the DRAIN cycle.
  - Number of samples equals the number of instructions issued.
  - Per sample: last_out = io_in; signature = {signature[OW-2:0], signature[OW-1]} ^ io_in (rotate left by 1, then XOR).
- signature and last_out hold their values in IDLE until the next accepted start, which zeroes signature. last_out is not zeroed by start.
- busy = (state==RUN) or (state==DRAIN).
- Pointer and count widths: rd_ptr is log2(DEPTH) bits. count is one bit wider so that full (count==DEPTH) is representable.

Test Plan:
- Load and replay:
  - Reset, write 0x01, 0x02, 0x03, then start with loop_en=0.
  - Required: instr = 1, 2, 3 on three consecutive cycles; busy high for 4 cycles; done pulses on the 5th; count=3.
- Signature:
  - Same program, io_in forced to 0x80, 0x01, 0xFF on the three sample cycles.
  - Required: signature steps 0x80 → 0x00 → 0xFF; final signature=0xFF; last_out=0xFF.
- Overflow and clear:
  - Write DEPTH+1 words.
  - Required: count=16, overflow=1, the 17th word is not stored.
  - Then pulse clear. Required: count=0, overflow=0; start is ignored, busy stays 0.
- Looping:
  - Program 0x0A, 0x0B with loop_en=1, run 7 cycles, then assert stop while instr=0x0A.
  - Required: instr continues 0x0B, then DRAIN (instr=0), then done.
- Ignored controls:
  - During RUN, pulse wr_en (wr_data=0x3F) and start.
  - Required: count unchanged, replay sequence unchanged, done pulses exactly once.
- Async reset mid-run:
  - Drop rst for half a cycle during RUN.
  - Required: instr=0, busy=0 immediately (before the next edge); count=0; no done pulse afterwards.
